irq_target_ctrl: RTL and testbench
==================================

// Module: irq_target_ctrl
// PURPOSE
// - Target-side receiver for one interrupt target of the interrupt router. Takes that target's
//   NumIntrSrc-wide slice of the distributed interrupt vector.
// - Latches pending interrupts, level or edge per source, and arbitrates among them round-robin.
// - Offers one interrupt ID at a time to the core over a valid/ready claim handshake.
// - Blocks further offers until the core signals completion of the claimed ID (non-nesting).
// PARAMETERS
// - NumIntrSrc  64                   number of interrupt sources (>=2)
// - IdWidth     $clog2(NumIntrSrc)   width of interrupt ID fields
// PORTS
// - clk_i             in   1           clock; single clock domain
// - rst_i             in   1           reset, synchronous, active-high
// - irqs_i            in   NumIntrSrc  this target's slice of the router's distributed irqs
// - edge_mode_i       in   NumIntrSrc  per source: 1 = rising-edge triggered, 0 = level
// - enable_i          in   NumIntrSrc  per-source enable; masks offer only, pending still latches
// - irq_valid_o       out  1           an interrupt is offered to the core
// - irq_id_o          out  IdWidth     ID of the offered interrupt
// - irq_ready_i       in   1           core claims offered ID (handshake = valid & ready)
// - complete_valid_i  in   1           core finished servicing an ID (one-cycle pulse)
// - complete_id_i     in   IdWidth     ID being completed
// - in_service_o      out  1           a claimed ID awaits completion
// - pending_o         out  NumIntrSrc  current pending vector (debug/status)
// BEHAVIOUR
// - Reset: irq_valid_o=0, irq_id_o=0, in_service_o=0, pending_o=0.
//   Edge-detect history=0, RR pointer=0, FSM=IDLE. A reset mid-offer or mid-service discards all state.
// - Edge mode: pending[k] sets when irqs_i[k]=1 and its previous sample=0.
//   It clears on the claim handshake of k.
//   Set and clear in the same cycle: set wins (a new edge is never lost).
// - Level mode: pending[k] = registered irqs_i[k]; claim does not clear it.
// - Eligible[k] = pending[k] & enable_i[k] & ~(in-service k).
// - Arbitration: the first eligible index at or above the RR pointer, wrapping from NumIntrSrc-1 to 0.
//   On a handshake the pointer becomes (id+1) mod NumIntrSrc.
// - FSM:
//   - IDLE -> OFFER when any source is eligible: register irq_id_o, assert irq_valid_o.
//   - OFFER: irq_valid_o and irq_id_o are held stable until handshake. No retraction, even if the
//     source deasserts or is disabled; the core handles spurious claims.
//   - OFFER -> BUSY on handshake: irq_valid_o=0 next cycle, in_service_o=1, store the ID.
//   - BUSY -> IDLE on complete_valid_i with complete_id_i == stored ID.
//     A mismatched ID, or complete_valid_i in IDLE/OFFER, is ignored.
// - Latency: irqs_i[k] rises, sampled at edge N (state IDLE, no other eligible source):
//   irq_valid_o=1 after edge N+2.
//   After a completing pulse at edge M with another source eligible: irq_valid_o=1 after edge M+1.
// - Same cycle complete and a new edge on the completed source: pending sets, offered next round.
// - Level source still high after completion: re-offered (core must clear at source first).
// CONFIGURATION
// - IRQ_TARGET_CTRL_SYNC_EN defined: irqs_i passes a 2-flop synchronizer (reset 0) before edge
//   detect/pending. This adds 2 cycles to input-to-valid latency (N+4) for asynchronous sources.
// - Not defined: irqs_i is used directly; latency as above.
// TESTING
// - Edge mode, src 5 pulses 1 cycle at edge 10 -> irq_valid_o=1, irq_id_o=5 after edge 12.
//   Ready at 14 -> valid=0, in_service_o=1 after 14. Complete(5) -> idle, pending_o=0.
// - Srcs 3 and 7 edge simultaneously, pointer=0 -> offer 3; after claim and complete(3) -> offer 7.
//   Pointer is then 8, so a fresh edge on 3 with one on 9 -> 9 is offered first.
// - BUSY on ID 2 and complete_id_i=4 pulses -> no state change.
//   complete(2) -> IDLE; next eligible is offered 1 cycle later.
// - Level src 12 held high through claim/complete -> re-offered after completion.
//   Drop it, then complete -> no offer.
// - Disabled src 20 gets an edge -> pending_o[20]=1, no offer. enable_i[20]=1 -> offer ID 20.
//   Assert rst_i during OFFER -> all outputs 0 next cycle.
// - With IRQ_TARGET_CTRL_SYNC_EN: the first scenario gives valid after edge 14.

Source files
------------

// File: rtl/irq_target_ctrl.sv
// -----------------------------------------------------------------------------
// irq_target_ctrl
// Receiver for a single interrupt target. It latches pending interrupts (edge
// or level per source), picks one round-robin, offers it to the core over a
// valid/ready claim handshake and then waits for the core to complete that ID
// before offering another one (no nesting).
//
// Optional feature macro: IRQ_TARGET_CTRL_SYNC_EN
//   defined     -> irqs_i passes through a 2-flop synchronizer (reset 0)
//                  before the sample/edge-detect stage (+2 cycles latency)
//   not defined -> irqs_i feeds the sample stage directly
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   irqs_i           interrupt request per source
//   edge_mode_i      per source: 1 = rising-edge, 0 = level
//   enable_i         per source: masks offering only, pending still latches
//   irq_valid_o      an interrupt ID is offered to the core
//   irq_id_o         offered (and later in-service) interrupt ID
//   irq_ready_i      core claims the offered ID
//   complete_valid_i core finished an ID (one-cycle pulse)
//   complete_id_i    ID being completed
//   in_service_o     a claimed ID awaits completion
//   pending_o        current pending vector
// -----------------------------------------------------------------------------
module irq_target_ctrl #(
  parameter int NumIntrSrc = 64,
  parameter int IdWidth    = $clog2(NumIntrSrc)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumIntrSrc-1:0] irqs_i,
  input  logic [NumIntrSrc-1:0] edge_mode_i,
  input  logic [NumIntrSrc-1:0] enable_i,
  output logic                  irq_valid_o,
  output logic [IdWidth-1:0]    irq_id_o,
  input  logic                  irq_ready_i,
  input  logic                  complete_valid_i,
  input  logic [IdWidth-1:0]    complete_id_i,
  output logic                  in_service_o,
  output logic [NumIntrSrc-1:0] pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam logic [NumIntrSrc-1:0] OneHotLsb = {{(NumIntrSrc-1){1'b0}}, 1'b1};

  state_e                  r_state;
  state_e                  w_state_next;
  logic [NumIntrSrc-1:0]   w_irq_in;
  logic [NumIntrSrc-1:0]   r_irq_s;      // sampled request
  logic [NumIntrSrc-1:0]   r_irq_d;      // edge-detect history
  logic [NumIntrSrc-1:0]   r_pending;
  logic [NumIntrSrc-1:0]   w_pending_next;
  logic [NumIntrSrc-1:0]   w_rise;
  logic [NumIntrSrc-1:0]   w_id_onehot;
  logic [NumIntrSrc-1:0]   w_clr;
  logic [NumIntrSrc-1:0]   w_in_service_mask;
  logic [NumIntrSrc-1:0]   w_eligible;
  logic [IdWidth-1:0]      r_ptr;
  logic [IdWidth-1:0]      w_ptr_next;
  logic [IdWidth-1:0]      r_id;
  logic                    r_valid;
  logic                    r_in_service;
  logic                    w_arb_found;
  logic [IdWidth-1:0]      w_arb_id;
  logic                    w_handshake;
  int                      w_idx;

`ifdef IRQ_TARGET_CTRL_SYNC_EN
  logic [NumIntrSrc-1:0] r_sync1;
  logic [NumIntrSrc-1:0] r_sync2;

  // two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irqs_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_in = r_sync2;
`else
  assign w_irq_in = irqs_i;
`endif

  // Pending update: edge sources set on a rising sample and clear on their own
  // claim, with the set term ORed last so a new edge never gets lost. Level
  // sources simply mirror the sampled request.
  assign w_rise            = r_irq_s & ~r_irq_d;
  assign w_id_onehot       = OneHotLsb << r_id;
  assign w_clr             = w_handshake ? w_id_onehot : '0;
  assign w_pending_next    = (edge_mode_i & ((r_pending & ~w_clr) | w_rise))
                           | (~edge_mode_i & r_irq_s);
  assign w_in_service_mask = (r_state == ST_BUSY) ? w_id_onehot : '0;
  assign w_eligible        = r_pending & enable_i & ~w_in_service_mask;
  assign w_ptr_next        = (r_id == IdWidth'(NumIntrSrc - 1)) ? '0 : r_id + IdWidth'(1);

  // round-robin search: first eligible index at or above the pointer, wrapping
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_id    = '0;
    w_idx       = 0;
    for (int i = 0; i < NumIntrSrc; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NumIntrSrc) begin
        w_idx = w_idx - NumIntrSrc;
      end else begin
        w_idx = w_idx;
      end
      if (!w_arb_found && w_eligible[w_idx]) begin
        w_arb_found = 1'b1;
        w_arb_id    = IdWidth'(w_idx);
      end else begin
        w_arb_found = w_arb_found;
      end
    end
  end

  // next-state logic and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_handshake  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) w_state_next = ST_OFFER;
        else             w_state_next = ST_IDLE;
      end
      ST_OFFER: begin
        // the offer is never retracted; only the claim moves us on
        if (irq_ready_i) begin
          w_handshake  = 1'b1;
          w_state_next = ST_BUSY;
        end else begin
          w_state_next = ST_OFFER;
        end
      end
      ST_BUSY: begin
        if (complete_valid_i && (complete_id_i == r_id)) w_state_next = ST_IDLE;
        else                                             w_state_next = ST_BUSY;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // sampling, pending, pointer, ID and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_s      <= '0;
      r_irq_d      <= '0;
      r_pending    <= '0;
      r_ptr        <= '0;
      r_id         <= '0;
      r_valid      <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_irq_s      <= w_irq_in;
      r_irq_d      <= r_irq_s;
      r_pending    <= w_pending_next;
      r_valid      <= (w_state_next == ST_OFFER);
      r_in_service <= (w_state_next == ST_BUSY);
      // the ID is captured once when the offer starts and then held through
      // OFFER and BUSY, where it doubles as the in-service ID
      if ((r_state == ST_IDLE) && w_arb_found) r_id <= w_arb_id;
      else                                     r_id <= r_id;
      if (w_handshake) r_ptr <= w_ptr_next;
      else             r_ptr <= r_ptr;
    end
  end

  assign irq_valid_o  = r_valid;
  assign irq_id_o     = r_id;
  assign in_service_o = r_in_service;
  assign pending_o    = r_pending;

endmodule

// File: tb/tb_irq_target_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for irq_target_ctrl: cycle-level reference model feeding an
// expectation queue, a negedge monitor comparing every cycle, plus directed
// scenarios with hand-derived constants and a randomized phase.
// -----------------------------------------------------------------------------
module tb_irq_target_ctrl;

  localparam int N  = 64;
  localparam int IW = 6;
`ifdef IRQ_TARGET_CTRL_SYNC_EN
  localparam int SyncExtra = 2;
`else
  localparam int SyncExtra = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irqs = '0;
  logic [N-1:0]  edge_mode = '1;
  logic [N-1:0]  enable = '1;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          ready = 1'b0;
  logic          cv = 1'b0;
  logic [IW-1:0] cid = '0;
  logic          in_service;
  logic [N-1:0]  pending;

  always #5 clk = ~clk;

  irq_target_ctrl #(.NumIntrSrc(N), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst), .irqs_i(irqs), .edge_mode_i(edge_mode),
    .enable_i(enable), .irq_valid_o(irq_valid), .irq_id_o(irq_id),
    .irq_ready_i(ready), .complete_valid_i(cv), .complete_id_i(cid),
    .in_service_o(in_service), .pending_o(pending)
  );

  typedef struct {
    logic          valid;
    logic [IW-1:0] id;
    logic          insvc;
    logic [N-1:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = nothing offered, 1 = offering m_id, 2 = m_id claimed
  logic [N-1:0] m_s = '0, m_d = '0, m_pend = '0, m_sy1 = '0, m_sy2 = '0;
  int m_ptr = 0, m_phase = 0, m_id = 0;

  task automatic model_step();
    logic [N-1:0] in_vec;
    logic [N-1:0] npend;
    bit hs;
    int pick;
    exp_t t;
    if (rst) begin
      m_s = '0; m_d = '0; m_pend = '0; m_sy1 = '0; m_sy2 = '0;
      m_ptr = 0; m_phase = 0; m_id = 0;
    end else begin
`ifdef IRQ_TARGET_CTRL_SYNC_EN
      in_vec = m_sy2; m_sy2 = m_sy1; m_sy1 = irqs;
`else
      in_vec = irqs;
`endif
      hs = (m_phase == 1) && ready;
      for (int k = 0; k < N; k++) begin
        if (edge_mode[k]) npend[k] = (m_pend[k] && !(hs && m_id == k)) || (m_s[k] && !m_d[k]);
        else              npend[k] = m_s[k];
      end
      pick = -1;
      if (m_phase == 0)
        for (int j = 0; j < N; j++) begin
          int k;
          k = (m_ptr + j) % N;
          if (pick < 0 && m_pend[k] && enable[k]) pick = k;
        end
      case (m_phase)
        0: if (pick >= 0) begin m_phase = 1; m_id = pick; end
        1: if (ready) begin m_phase = 2; m_ptr = (m_id + 1) % N; end
        2: if (cv && int'(cid) == m_id) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_d = m_s; m_s = in_vec; m_pend = npend;
    end
    t.valid = (m_phase == 1);
    t.id    = IW'(m_id);
    t.insvc = (m_phase == 2);
    t.pend  = m_pend;
    exp_q.push_back(t);
  endtask

  // monitor: one expectation per clock edge, compared half a cycle later
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_valid", 64'(irq_valid), 64'(mon_e.valid));
      check("sb_id", 64'(irq_id), 64'(mon_e.id));
      check("sb_in_service", 64'(in_service), 64'(mon_e.insvc));
      check("sb_pending", 64'(pending), 64'(mon_e.pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic pulse2(input int a, input int b);
    irqs[a] = 1'b1; irqs[b] = 1'b1; tick(); irqs = '0;
  endtask

  task automatic claim();
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic complete(input int id);
    cv = 1'b1; cid = IW'(id); tick(); cv = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_valid", 64'(irq_valid), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);

    // single edge on src 5: offer two edges after the sampling edge
    irqs[5] = 1'b1; tick(); irqs = '0;
    ticks(1 + SyncExtra);
    check("s1_no_early_valid", 64'(irq_valid), 64'd0);
    tick();
    check("s1_valid", 64'(irq_valid), 64'd1);
    check("s1_id", 64'(irq_id), 64'd5);
    tick();
    check("s1_held", 64'(irq_valid), 64'd1);
    claim();
    check("s1_claim_valid", 64'(irq_valid), 64'd0);
    check("s1_claim_insvc", 64'(in_service), 64'd1);
    complete(5);
    check("s1_done_insvc", 64'(in_service), 64'd0);
    check("s1_done_pending", 64'(pending), 64'd0);
    ticks(3);

    // simultaneous 3 and 7 with pointer 0, then pointer-driven order 9 before 3
    do_reset();
    pulse2(3, 7);
    ticks(2 + SyncExtra);
    check("s2_first_id", 64'(irq_id), 64'd3);
    claim(); complete(3);
    check("s2_idle_gap", 64'(irq_valid), 64'd0);
    tick();
    check("s2_second_valid", 64'(irq_valid), 64'd1);
    check("s2_second_id", 64'(irq_id), 64'd7);
    claim(); complete(7);
    ticks(2);
    pulse2(3, 9);
    ticks(2 + SyncExtra);
    check("s2_rr_id", 64'(irq_id), 64'd9);
    claim(); complete(9); tick();
    check("s2_rr_next_id", 64'(irq_id), 64'd3);
    claim(); complete(3);
    ticks(2);

    // mismatched completion ignored
    do_reset();
    pulse2(2, 6);
    ticks(2 + SyncExtra);
    check("s3_id", 64'(irq_id), 64'd2);
    claim();
    complete(4);
    check("s3_wrong_complete", 64'(in_service), 64'd1);
    complete(2);
    check("s3_right_complete", 64'(in_service), 64'd0);
    tick();
    check("s3_next_valid", 64'(irq_valid), 64'd1);
    check("s3_next_id", 64'(irq_id), 64'd6);
    claim(); complete(6);
    ticks(2);

    // level source 12 held high is re-offered; dropped first, it is not
    edge_mode[12] = 1'b0; irqs[12] = 1'b1;
    ticks(3 + SyncExtra);
    check("s4_id", 64'(irq_id), 64'd12);
    claim(); ticks(2); complete(12); tick();
    check("s4_reoffer_valid", 64'(irq_valid), 64'd1);
    check("s4_reoffer_id", 64'(irq_id), 64'd12);
    claim(); irqs[12] = 1'b0;
    ticks(3 + SyncExtra);
    complete(12); ticks(3);
    check("s4_no_reoffer", 64'(irq_valid), 64'd0);
    edge_mode = '1;

    // disabled source still latches; enabling it offers it; reset clears all
    enable[20] = 1'b0;
    irqs[20] = 1'b1; tick(); irqs = '0;
    ticks(3 + SyncExtra);
    check("s5_pending20", 64'(pending[20]), 64'd1);
    check("s5_masked", 64'(irq_valid), 64'd0);
    enable[20] = 1'b1;
    tick();
    check("s5_valid", 64'(irq_valid), 64'd1);
    check("s5_id", 64'(irq_id), 64'd20);
    rst = 1'b1; tick(); rst = 1'b0;
    check("s5_rst_valid", 64'(irq_valid), 64'd0);
    check("s5_rst_insvc", 64'(in_service), 64'd0);
    check("s5_rst_pending", 64'(pending), 64'd0);
    check("s5_rst_id", 64'(irq_id), 64'd0);

    // randomized phase, checked by the scoreboard every cycle
    for (int seg = 0; seg < 6; seg++) begin
      edge_mode = {$urandom, $urandom};
      enable    = {$urandom, $urandom} | {$urandom, $urandom};
      for (int c = 0; c < 500; c++) begin
        irqs  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        ready = ($urandom_range(1, 0) == 1);
        if (m_phase == 2 && $urandom_range(3, 0) == 0) begin
          cv  = 1'b1;
          cid = ($urandom_range(3, 0) == 0) ? IW'($urandom) : IW'(m_id);
        end else begin
          cv  = ($urandom_range(15, 0) == 0);
          cid = IW'($urandom);
        end
        rst = ($urandom_range(799, 0) == 0);
        tick();
      end
    end
    rst = 1'b0; cv = 1'b0; ready = 1'b0; irqs = '0;
    ticks(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
